// File: rtl/ft_recovery_pkg.sv
// Shared types and default sizing for the fault-tolerance recovery path.
package ft_recovery_pkg;

  localparam int unsigned FT_NUM_REGS = 32;
  localparam int unsigned FT_ADDR_W   = 5;
  localparam int unsigned FT_DATA_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_PC   = 2'd2,
    ST_DONE = 2'd3
  } ft_rec_state_e;

endpackage

// File: rtl/ft_recovery_engine.sv
// Recovery responder: copies x1..x(NUM_REGS-1) from the healthy core RF into
// the faulty core RF, optionally loads the PC, then signals done (4-phase).
// Optional PC transfer is enabled by defining FT_RECOVERY_PC_EN.
module ft_recovery_engine
  import ft_recovery_pkg::*;
#(
  parameter int unsigned NUM_REGS = FT_NUM_REGS,
  parameter int unsigned ADDR_W   = FT_ADDR_W,
  parameter int unsigned DATA_W   = FT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              recover_i,
  output logic              recovery_done_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o
`ifdef FT_RECOVERY_PC_EN
  ,
  input  logic [DATA_W-1:0] pc_i,
  output logic [DATA_W-1:0] pc_o,
  output logic              pc_we_o
`endif
);

  // One extra bit so NUM_REGS == 2^ADDR_W never wraps.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_REG = CNT_W'(NUM_REGS - 1);

  ft_rec_state_e    state_q, state_d;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;
  logic             rd_act, wr_act;
`ifdef FT_RECOVERY_PC_EN
  logic [DATA_W-1:0] pc_q;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; copy exits after the write of the last register commits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (recover_i) state_d = ST_COPY;
      ST_COPY: begin
        if (wr_act && (wr_cnt == LAST_REG)) begin
`ifdef FT_RECOVERY_PC_EN
          state_d = ST_PC;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_PC:   state_d = ST_DONE;
      ST_DONE: if (!recover_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read counter, trailing write pointer and captured PC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt <= '0;
      rd_act <= 1'b0;
      wr_cnt <= '0;
      wr_act <= 1'b0;
`ifdef FT_RECOVERY_PC_EN
      pc_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (recover_i) begin
            rd_cnt <= CNT_W'(1);
            rd_act <= 1'b1;
            wr_cnt <= '0;
            wr_act <= 1'b0;
`ifdef FT_RECOVERY_PC_EN
            pc_q   <= pc_i;
`endif
          end
        end
        ST_COPY: begin
          wr_cnt <= rd_cnt;
          wr_act <= rd_act;
          if (rd_act) begin
            if (rd_cnt == LAST_REG) rd_act <= 1'b0;
            else                    rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        default: begin
          rd_act <= 1'b0;
          wr_act <= 1'b0;
        end
      endcase
    end
  end

  // Outputs decoded from state and datapath registers only.
  always_comb begin
    recovery_done_o = 1'b0;
    busy_o          = (state_q != ST_IDLE);
    rf_raddr_o      = '0;
    rf_we_o         = 1'b0;
    rf_waddr_o      = '0;
`ifdef FT_RECOVERY_PC_EN
    pc_o            = '0;
    pc_we_o         = 1'b0;
`endif
    case (state_q)
      ST_COPY: begin
        if (rd_act) rf_raddr_o = rd_cnt[ADDR_W-1:0];
        if (wr_act) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = wr_cnt[ADDR_W-1:0];
        end
      end
`ifdef FT_RECOVERY_PC_EN
      ST_PC: begin
        pc_we_o = 1'b1;
        pc_o    = pc_q;
      end
`endif
      ST_DONE: recovery_done_o = 1'b1;
      default: ;
    endcase
  end

  // Write data is the healthy RF read data, one cycle after its address.
  assign rf_wdata_o = rf_rdata_i;

endmodule

// File: doc/ft_recovery_engine.md
# ft_recovery_engine

Responder side of the fault-tolerance recovery handshake. When the FT controller raises `recover_i`, this block copies the architectural state of the healthy core into the faulty core: integer registers x1..x(NUM_REGS-1), then the PC. It then raises `recovery_done_o` back to the controller. It sits between `ft_control` and the two cores' register-file debug ports.

## Interface
- `NUM_REGS`, default 32: architectural register count; x0 is never copied.
- `ADDR_W`, default 5: register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- `DATA_W`, default 32: register and PC width.
- `clk_i`  in  1: single clock; all logic rising-edge.
- `rst_i`  in  1: asynchronous, active-high reset.
- `recover_i`  in  1: recovery request from FT controller; level, 4-phase handshake.
- `recovery_done_o`  out  1: recovery complete; held until `recover_i` is sampled low.
- `busy_o`  out  1: high in every state except IDLE.
- `rf_raddr_o`  out  ADDR_W: read address to healthy core RF.
- `rf_rdata_i`  in  DATA_W: healthy RF read data; synchronous read, valid the cycle after the address.
- `rf_we_o`  out  1: write enable to faulty core RF.
- `rf_waddr_o`  out  ADDR_W: write address to faulty core RF.
- `rf_wdata_o`  out  DATA_W: write data; combinational pass-through of `rf_rdata_i`.
- `pc_i`  in  DATA_W: healthy core PC (macro-dependent).
- `pc_o`  out  DATA_W: PC value for the faulty core (macro-dependent).
- `pc_we_o`  out  1: PC load strobe to the faulty core (macro-dependent).

## Operation
- FSM states: IDLE, COPY, PC, DONE.
- IDLE -> COPY when `recover_i`=1 is sampled. At that edge, `pc_i` is captured into a register and the read counter is loaded with 1.
- COPY:
  - `rf_raddr_o` = read counter, which advances by 1 per cycle from 1 to NUM_REGS-1.
  - A write pointer trails the read counter by one cycle.
  - `rf_we_o`=1 whenever the write pointer is valid; `rf_waddr_o` = write pointer.
  - Exit to PC after the edge that commits the write of register NUM_REGS-1.
- PC: one cycle with `pc_we_o`=1 and `pc_o` = the captured PC. Go to DONE.
- DONE: `recovery_done_o`=1. Go to IDLE on the first edge where `recover_i`=0.
- Counters are ADDR_W+1 bits wide so that NUM_REGS = 2^ADDR_W terminates without wrap-around. Addresses never reach 0 or NUM_REGS.
- If `recover_i` is deasserted mid-copy, it is ignored; the copy always completes.
  - If `recover_i` is already low when DONE is entered, `recovery_done_o` is high for exactly one cycle.
- No new request is accepted until the FSM is back in IDLE.
- `rst_i` mid-operation: immediate return to IDLE; all outputs 0; the partial copy is abandoned and the controller must re-request.

## Timing
- Reset values: `recovery_done_o`, `busy_o`, `rf_we_o`, `pc_we_o` = 0; `rf_raddr_o`, `rf_waddr_o`, `pc_o` = 0.
- `rf_wdata_o` is a pass-through and has no reset value.
- Cycle n means the cycle after edge En. E0 is the edge that samples `recover_i`=1.
- Reads: register k in cycle k, for k = 1..NUM_REGS-1.
- Writes: register k in cycle k+1, committed at edge E(k+1).
- With the default NUM_REGS=32:
  - Writes occur in cycles 2..32.
  - PC write in cycle 33.
  - `recovery_done_o` rises in cycle 34.
- Latency from request sample to done: NUM_REGS+2 cycles, or NUM_REGS+1 without the PC feature.
- `busy_o` is high from cycle 1 through the last DONE cycle.

## Configuration
- `FT_RECOVERY_PC_EN` defined:
  - `pc_i`, `pc_o`, `pc_we_o` ports exist.
  - PC state is present as described above.
- `FT_RECOVERY_PC_EN` undefined:
  - The three PC ports are removed and the PC state is absent.
  - COPY goes directly to DONE; with defaults, done rises in cycle 33.

## Structure
- `ft_recovery_pkg` holds:
  - the FSM state enum;
  - default constants `FT_NUM_REGS`, `FT_ADDR_W`, `FT_DATA_W`, shared with `ft_control` and the core wrappers.
- Single module with no sub-module; the counter and FSM are small enough to be inline.

## Test plan
- Basic copy: healthy RF model returns data = 0xA000_0000 + addr; pulse `recover_i` high in cycle 0 -> faulty RF holds x1..x31 = 0xA000_0001..0xA000_001F, x0 untouched, `recovery_done_o` rises in cycle 34.
- PC transfer: `pc_i` = 0x0000_1F40 at request, then changed to 0xDEAD_BEEF -> exactly one `pc_we_o` pulse in cycle 33 with `pc_o` = 0x0000_1F40.
- Handshake hold: `recover_i` held high for 10 cycles after done -> `recovery_done_o` stays high for all 10; IDLE and `busy_o`=0 one cycle after `recover_i` is sampled low.
- Early drop: `recover_i` high for 1 cycle only -> full copy still occurs, then `recovery_done_o` high for exactly 1 cycle.
- Reset mid-copy: assert `rst_i` in cycle 12 -> all outputs 0 asynchronously, no further writes; a new request after release restarts at address 1.
- Macro off: build without `FT_RECOVERY_PC_EN` -> done in cycle 33, no PC ports present.
